// File: rtl/clk_gen_ctrl.sv
// Programmable gated/divided clock generator: counted or free-running output
// periods with a start/stop handshake, edge strobes and a completed-period count.
module clk_gen_ctrl #(
  parameter int HALF_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [HALF_W-1:0] cfg_half,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic              start,
  input  logic              stop,
  output logic              clk_out,
  output logic              rise_pulse,
  output logic              fall_pulse,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  period_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state_reg, state_next;
  logic [HALF_W-1:0]   half_cfg_reg, half_cfg_next;
  logic [HALF_W-1:0]   half_cnt_reg, half_cnt_next;
  logic [CNT_W-1:0]    count_cfg_reg, count_cfg_next;
  logic [CNT_W-1:0]    period_cnt_reg, period_cnt_next;
  logic                stop_pending_reg, stop_pending_next;
  logic                clk_out_reg, clk_out_next;
  logic                rise_reg, rise_next;
  logic                fall_reg, fall_next;
  logic                done_reg, done_next;
  logic                err_reg, err_next;

  logic                start_ok;
  logic                phase_end;
  logic                low_end;
  logic [CNT_W-1:0]    new_count;
  logic                finish;

  assign start_ok  = (state_reg == IDLE) && start && (cfg_half != '0);
  assign phase_end = (state_reg == RUN) && (half_cnt_reg == half_cfg_reg - HALF_W'(1));
  assign low_end   = phase_end && !clk_out_reg;
  assign new_count = period_cnt_reg + CNT_W'(1);
  // A stop sampled on the closing edge of a period counts just like a pending one.
  assign finish    = low_end &&
                     (((count_cfg_reg != '0) && (new_count == count_cfg_reg)) ||
                      stop_pending_reg || stop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      half_cfg_reg     <= '0;
      half_cnt_reg     <= '0;
      count_cfg_reg    <= '0;
      period_cnt_reg   <= '0;
      stop_pending_reg <= 1'b0;
      clk_out_reg      <= 1'b0;
      rise_reg         <= 1'b0;
      fall_reg         <= 1'b0;
      done_reg         <= 1'b0;
      err_reg          <= 1'b0;
    end else begin
      state_reg        <= state_next;
      half_cfg_reg     <= half_cfg_next;
      half_cnt_reg     <= half_cnt_next;
      count_cfg_reg    <= count_cfg_next;
      period_cnt_reg   <= period_cnt_next;
      stop_pending_reg <= stop_pending_next;
      clk_out_reg      <= clk_out_next;
      rise_reg         <= rise_next;
      fall_reg         <= fall_next;
      done_reg         <= done_next;
      err_reg          <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_ok) state_next = RUN;
      RUN:     if (finish)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    half_cfg_next     = half_cfg_reg;
    half_cnt_next     = half_cnt_reg;
    count_cfg_next    = count_cfg_reg;
    period_cnt_next   = period_cnt_reg;
    stop_pending_next = stop_pending_reg;
    clk_out_next      = clk_out_reg;
    rise_next         = 1'b0;
    fall_next         = 1'b0;
    done_next         = 1'b0;
    err_next          = 1'b0;
    case (state_reg)
      IDLE: begin
        stop_pending_next = 1'b0;
        clk_out_next      = 1'b0;
        if (start_ok) begin
          half_cfg_next   = cfg_half;
          count_cfg_next  = cfg_count;
          half_cnt_next   = '0;
          period_cnt_next = '0;
          clk_out_next    = 1'b1;
          rise_next       = 1'b1;
        end else if (start) begin
          err_next = 1'b1;
        end
      end
      RUN: begin
        if (stop) stop_pending_next = 1'b1;
        if (phase_end) begin
          half_cnt_next = '0;
          if (clk_out_reg) begin
            clk_out_next = 1'b0;
            fall_next    = 1'b1;
          end else begin
            period_cnt_next = new_count;
            if (finish) begin
              done_next         = 1'b1;
              stop_pending_next = 1'b0;
            end else begin
              clk_out_next = 1'b1;
              rise_next    = 1'b1;
            end
          end
        end else begin
          half_cnt_next = half_cnt_reg + HALF_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign clk_out    = clk_out_reg;
  assign rise_pulse = rise_reg;
  assign fall_pulse = fall_reg;
  assign busy       = (state_reg == RUN);
  assign done       = done_reg;
  assign err        = err_reg;
  assign period_cnt = period_cnt_reg;

endmodule

// File: tb/tb_clk_gen_ctrl.sv
// Bench for clk_gen_ctrl: waveform model derived from elapsed-cycle arithmetic,
// per-cycle comparison, directed scenarios with literal pins, then random traffic.
module tb_clk_gen_ctrl;
  localparam int HALF_W = 16;
  localparam int CNT_W  = 8;
  localparam longint INF = 64'h7fff_ffff_ffff_ffff;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [HALF_W-1:0] cfg_half = '0;
  logic [CNT_W-1:0]  cfg_count = '0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              clk_out, rise_pulse, fall_pulse, busy, done, err;
  logic [CNT_W-1:0]  period_cnt;

  clk_gen_ctrl #(.HALF_W(HALF_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_half(cfg_half), .cfg_count(cfg_count),
    .start(start), .stop(stop), .clk_out(clk_out), .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse), .busy(busy), .done(done), .err(err),
    .period_cnt(period_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a run is described by its start edge, H, C and its end edge; every
  // output follows from the elapsed cycle count k since the start.
  longint           edge_n = 0;
  bit               m_valid = 0;
  bit               m_busy = 0;
  longint           t0 = 0, end_e = INF;
  longint           m_h = 1, m_c = 0;
  logic [CNT_W-1:0] m_pc = '0;
  logic             exp_clk = 0, exp_rise = 0, exp_fall = 0, exp_done = 0, exp_err = 0;

  initial begin
    forever begin
      longint k, p, b;
      @(posedge clk);
      exp_rise = 0; exp_fall = 0; exp_done = 0; exp_err = 0;
      if (rst) begin
        m_busy = 0; m_pc = '0; exp_clk = 0; m_valid = 1;
      end else if (!m_busy) begin
        exp_clk = 0;
        if (start) begin
          if (cfg_half != 0) begin
            m_busy = 1; t0 = edge_n; m_h = longint'(cfg_half); m_c = longint'(cfg_count);
            end_e = (m_c != 0) ? 2 * m_h * m_c : INF;
            exp_clk = 1; exp_rise = 1; m_pc = '0;
          end else begin
            exp_err = 1;
          end
        end
      end else begin
        k = edge_n - t0;
        p = 2 * m_h;
        if (stop) begin
          b = ((k + p - 1) / p) * p;
          if (b < end_e) end_e = b;
        end
        m_pc = CNT_W'(k / p);
        if (k == end_e) begin
          m_busy = 0; exp_done = 1; exp_clk = 0;
        end else begin
          exp_clk  = (k % p) < m_h;
          exp_rise = (k % p) == 0;
          exp_fall = (k % p) == m_h;
        end
      end
      edge_n++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        checks++;
        if ({clk_out, rise_pulse, fall_pulse, busy, done, err, period_cnt} !==
            {exp_clk, exp_rise, exp_fall, m_busy, exp_done, exp_err, m_pc}) begin
          errors++;
          $display("FAIL model cycle %0d: got clk=%b rise=%b fall=%b busy=%b done=%b err=%b cnt=%0d expected clk=%b rise=%b fall=%b busy=%b done=%b err=%b cnt=%0d",
                   edge_n - 1, clk_out, rise_pulse, fall_pulse, busy, done, err, period_cnt,
                   exp_clk, exp_rise, exp_fall, m_busy, exp_done, exp_err, m_pc);
        end
      end
    end
  end

  // Returns at the negedge inside cycle 0 of the new run.
  task automatic start_run(input int h, input int c);
    cfg_half = HALF_W'(h); cfg_count = CNT_W'(c); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset clk_out", clk_out, 0);
    check("reset busy", busy, 0);
    check("reset period_cnt", period_cnt, 0);
    check("reset done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    // H=10, C=5
    start_run(10, 5);
    check("h10 c0 rise", rise_pulse, 1);
    check("h10 c0 clk_out", clk_out, 1);
    repeat (10) @(negedge clk);
    check("h10 c10 fall", fall_pulse, 1);
    check("h10 c10 clk_out", clk_out, 0);
    repeat (90) @(negedge clk);
    check("h10 c100 done", done, 1);
    check("h10 c100 busy", busy, 0);
    check("h10 c100 period_cnt", period_cnt, 5);
    @(negedge clk);
    check("h10 c101 done", done, 0);
    check("h10 hold period_cnt", period_cnt, 5);

    // H=1, C=3
    start_run(1, 3);
    repeat (6) @(negedge clk);
    check("h1 c6 done", done, 1);
    check("h1 c6 period_cnt", period_cnt, 3);
    @(negedge clk);

    // free-run H=4, stop sampled at edge 13
    start_run(4, 0);
    repeat (12) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop c13 clk_out", clk_out, 0);
    repeat (3) @(negedge clk);
    check("stop c16 done", done, 1);
    check("stop c16 period_cnt", period_cnt, 2);
    @(negedge clk);

    // rejected start
    cfg_half = '0; cfg_count = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("zero err", err, 1);
    check("zero busy", busy, 0);
    check("zero period_cnt kept", period_cnt, 2);
    @(negedge clk);
    check("zero err single", err, 0);
    start_run(2, 1);
    repeat (4) @(negedge clk);
    check("after err done", done, 1);
    @(negedge clk);

    // start + stop in IDLE: stop discarded
    cfg_half = 16'd2; cfg_count = 8'd2; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("startstop busy", busy, 1);
    repeat (8) @(negedge clk);
    check("startstop c8 done", done, 1);
    check("startstop period_cnt", period_cnt, 2);
    @(negedge clk);

    // stop on terminal edge plus start during RUN
    start_run(3, 2);
    repeat (11) @(negedge clk);
    stop = 1'b1; start = 1'b1; cfg_half = 16'd7; cfg_count = 8'd1;
    @(negedge clk);
    stop = 1'b0; start = 1'b0;
    check("term c12 done", done, 1);
    @(negedge clk);
    check("term c13 done", done, 0);
    check("term c13 busy", busy, 0);

    // reset mid-run
    start_run(5, 0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst c8 outputs", {clk_out, rise_pulse, fall_pulse, busy, done, err}, 0);
    check("rst c8 period_cnt", period_cnt, 0);
    @(negedge clk);

    // period counter wrap in free-run
    start_run(1, 0);
    repeat (512) @(negedge clk);
    check("wrap c512 period_cnt", period_cnt, 0);
    check("wrap c512 busy", busy, 1);
    repeat (2) @(negedge clk);
    check("wrap c514 period_cnt", period_cnt, 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (4) @(negedge clk);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      start     = ($urandom_range(0, 7) == 0);
      stop      = ($urandom_range(0, 23) == 0);
      cfg_half  = HALF_W'($urandom_range(0, 5));
      cfg_count = CNT_W'($urandom_range(0, 3));
      rst       = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    start = 1'b0; stop = 1'b0; rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_gen_ctrl.md
# clk_gen_ctrl

Programmable clock-waveform controller that generates a gated, divided clock signal from the system clock. It produces a configurable number of output periods, or runs free, with a start/stop handshake. It also emits single-cycle edge strobes so downstream logic can act on rise and fall. It sits between test/control sequencers and any block that needs a slow, countable clock or clock-enable, replacing hand-written `always #N clk = ~clk` generators with synthesizable sequencing.

## Interface
- `HALF_W`, 16, width of the half-period configuration, in system-clock cycles.
- `CNT_W`, 8, width of the period-count configuration and of the completed-period counter.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_half`  in  HALF_W  half-period length in `clk` cycles; sampled only on an accepted start.
- `cfg_count`  in  CNT_W  number of output periods to generate; 0 means free-run until stop. Sampled on an accepted start.
- `start`  in  1  request to begin; honoured only in IDLE.
- `stop`  in  1  request graceful stop; honoured only while running.
- `clk_out`  out  1  generated waveform.
- `rise_pulse`  out  1  high for the one cycle in which `clk_out` first reads 1.
- `fall_pulse`  out  1  high for the one cycle in which `clk_out` first reads 0 after a high half.
- `busy`  out  1  high from start acceptance until completion.
- `done`  out  1  one-cycle pulse when the generator returns to IDLE.
- `err`  out  1  one-cycle pulse when a start is rejected because `cfg_half`==0.
- `period_cnt`  out  CNT_W  completed periods since the last accepted start.

## Operation
- States:
  - IDLE: `clk_out`=0, `busy`=0.
  - RUN: waveform active.
- Accepted start (IDLE, `start`=1, `cfg_half`≠0):
  - latch `cfg_half` and `cfg_count`; clear `period_cnt` and the half counter.
  - set `clk_out`=1, `rise_pulse`=1, `busy`=1; enter RUN.
- Start with `cfg_half`=0 in IDLE: pulse `err`, remain in IDLE, leave `period_cnt` unchanged.
- Period structure: a high half of `cfg_half` cycles followed by a low half of `cfg_half` cycles. Output period = 2×`cfg_half` cycles.
- Half counter: counts 0..`cfg_half`-1, then the phase ends.
  - At the end of a high half: `clk_out`←0, `fall_pulse`=1.
  - At the end of a low half: `period_cnt`+1, then take the first matching case:
    - (a) `cfg_count`≠0 and the new count equals `cfg_count`, or a stop is pending: go to IDLE, `done`=1, `busy`=0, `clk_out` stays 0.
    - (b) otherwise: `clk_out`←1, `rise_pulse`=1.
- Stop while running: sets an internal stop_pending flag. The current period always completes, so `clk_out` never ends high and never produces a runt pulse.
- `start` during RUN is ignored; latched configuration is unaffected. `stop` in IDLE is ignored.
- Start and stop asserted in the same cycle in IDLE: start is accepted, stop is discarded.
- Stop arriving in the cycle of the terminal count: exactly one `done`, no extra period.
- Free-run (`cfg_count`=0): `period_cnt` wraps from 2^CNT_W-1 to 0 without terminating.
- `period_cnt` holds its final value in IDLE until the next accepted start.
- `cfg_half`=1 is legal: `clk_out` toggles every cycle.

## Timing
- "Cycle N" means the register state after rising edge N; the start is sampled at edge 0.
- With `cfg_half`=H:
  - `clk_out`=1 for cycles 0..H-1 and 0 for cycles H..2H-1.
  - `rise_pulse` is high in cycles 0, 2H, 4H, …; `fall_pulse` is high in cycles H, 3H, ….
- Completion of `cfg_count`=C periods: `done` and `busy`=0 in cycle 2HC; `period_cnt`=C from that cycle.
- All outputs are registered, with no combinational path from inputs to outputs.
- Reset values: `clk_out`=0, `rise_pulse`=0, `fall_pulse`=0, `busy`=0, `done`=0, `err`=0, `period_cnt`=0, state IDLE, stop_pending=0.
- Reset mid-run: in the next cycle all outputs are at reset values, with no `done` pulse and no `fall_pulse`.

## Test plan
- `cfg_half`=10, `cfg_count`=5, start at edge 0:
  - 20-cycle period: `clk_out` high in cycles 0-9, low in 10-19.
  - `rise_pulse` at 0/20/40/60/80; `fall_pulse` at 10/30/…/90.
  - `done` and `busy`=0 at cycle 100; `period_cnt`=5.
- `cfg_half`=1, `cfg_count`=3: `clk_out` reads 1,0,1,0,1,0, then `done` at cycle 6. Every cycle carries either `rise_pulse` or `fall_pulse`.
- Free-run with `cfg_half`=4, stop asserted at cycle 13 (mid period 2): the period completes, `done` at cycle 16, `period_cnt`=2, `clk_out` is 0 at stop.
- `cfg_half`=0 start: `err` pulses for one cycle; `busy` and `clk_out` stay 0. A following valid start runs normally.
- Simultaneous cases:
  - start+stop in IDLE: the run begins.
  - stop on the terminal edge with `cfg_count`=2, `cfg_half`=3 at cycle 12: a single `done` at cycle 12.
  - start during RUN: ignored.
- `rst` at cycle 7 of a `cfg_half`=5 run: cycle 8 shows all outputs at reset values, with no `done`. `CNT_W`=2 free-run: `period_cnt` wraps 3→0 and keeps running.
